lift_ctrl_scan: RTL and testbench
=================================

LIFT_CTRL_SCAN -- requirements
Module: lift_ctrl_scan

Interface
REQ-001 Parameter NUM_FLOORS, default 11: number of served floors, 2..64.
REQ-002 Parameter TRAVEL_CYCLES, default 8: clock cycles to travel one floor, >=1.
REQ-003 Parameter DOOR_CYCLES, default 4: cycles for each of door opening, door held open and door closing, >=1.
REQ-004 Localparam FW = $clog2(NUM_FLOORS): floor index width.
REQ-005 Clocking and reset: one clock; reset is synchronous and active-high.
REQ-006 Port list, clock and reset first:
  clk            in   1           rising-edge clock
  rst            in   1           synchronous active-high reset
  req            in   NUM_FLOORS  floor call buttons, one bit per floor, level or pulse
  door_obstacle  in   1           obstacle in doorway
  door_open_btn  in   1           cabin open-door request
  door_close_btn in   1           cabin close-door request
  up             out  1           motor driving cabin upward
  down           out  1           motor driving cabin downward
  door_opening   out  1           door motor opening
  door_closing   out  1           door motor closing
  ready          out  1           idle, door closed, no pending calls
  cur_floor      out  FW          current floor index
  pending        out  NUM_FLOORS  latched unserved calls

Function
REQ-007 The FSM states SHALL be IDLE, MOVING, OPENING, OPEN and CLOSING; the direction register dir SHALL be UP or DOWN.
REQ-008 pending SHALL OR in req every cycle; the bit for floor F SHALL clear only on the cycle the FSM enters OPENING at F, and that clear SHALL take priority over a same-cycle req[F].
REQ-009 In IDLE with pending[cur_floor]=1, the FSM SHALL enter OPENING on the next cycle.
REQ-010 In IDLE otherwise, if any call lies above cur_floor the FSM SHALL set dir=UP and enter MOVING; else if any call lies below, dir=DOWN and MOVING; both present selects the current dir (UP after reset).
REQ-011 In MOVING, a travel counter SHALL count TRAVEL_CYCLES cycles; on the last cycle cur_floor SHALL step +1 (UP) or -1 (DOWN) and the counter SHALL reload.
REQ-012 At each arrival, if pending[new floor]=1 the FSM SHALL enter OPENING; else it SHALL continue in dir.
REQ-013 When a call is served, the FSM SHALL keep dir if any call remains beyond cur_floor in dir, reverse if calls remain only in the opposite direction, and go to IDLE if none remain (SCAN ordering).
REQ-014 cur_floor SHALL never leave 0..NUM_FLOORS-1; no step SHALL be issued past an end floor.
REQ-015 OPENING and CLOSING SHALL each last DOOR_CYCLES cycles; OPEN SHALL last DOOR_CYCLES cycles, restarting its count on door_open_btn.
REQ-016 door_close_btn in OPEN SHALL cause CLOSING on the next cycle, unless door_obstacle or door_open_btn is asserted in the same cycle, in which case they win.
REQ-017 door_obstacle or door_open_btn during CLOSING SHALL cause OPENING on the next cycle, with the door counter reloaded.
REQ-018 At the end of CLOSING, the FSM SHALL apply REQ-013 to choose MOVING or IDLE.
REQ-019 Outputs SHALL be registered and decode only the current state: up/down=1 only in MOVING per dir; door_opening=1 only in OPENING; door_closing=1 only in CLOSING; ready=1 only in IDLE with pending==0.
REQ-020 up and down SHALL never both be 1; no motor output SHALL be 1 while any door output is 1.

Reset
REQ-021 While rst=1 the block SHALL set state=IDLE, dir=UP, cur_floor=0, pending=0, all counters=0, up/down/door_opening/door_closing=0 and ready=1, with all inputs ignored.
REQ-022 rst asserted mid-travel or mid-door SHALL abort immediately with the values of REQ-021; no floor position is retained.

Structure
REQ-023 A shared package lift_pkg SHALL hold the state enum, the dir enum and default parameter constants.
REQ-024 A sub-module lift_call_scan SHALL be combinational: from pending, cur_floor and dir it SHALL produce any_above, any_below, here and next_dir.
REQ-025 Counters SHALL be sized to $clog2(max(TRAVEL_CYCLES, DOOR_CYCLES)+1).

Verification
REQ-026 Reset, then a 1-cycle pulse req[3] with defaults -> up=1 for 24 cycles, cur_floor=3, door_opening 4, OPEN 4, door_closing 4 cycles, then ready=1 and pending=0.
REQ-027 At floor 5 moving UP with pending = floors {2, 7, 9} -> service order 7, 9, 2; dir reverses only after 9.
REQ-028 door_obstacle pulsed on the 2nd cycle of CLOSING -> OPENING on the next cycle, a full 4-cycle reopen, then a fresh OPEN and CLOSING.
REQ-029 req[0] at floor 0 in IDLE -> OPENING next cycle, no motor activity; req[10] reached at the top -> no further up step.
REQ-030 rst mid-MOVING between floors 4 and 5 -> next cycle cur_floor=0, up=0, pending=0; a prior req[8] is lost.
REQ-031 NUM_FLOORS=4, TRAVEL_CYCLES=1: req[3] from floor 0 -> arrival at floor 3 after 3 cycles; the up/down exclusivity assertion holds throughout.

Source files
------------

// File: rtl/lift_pkg.sv
// Shared types and default constants for the SCAN lift controller.
// Latency: none (types and constants only).
// Backpressure: none.
package lift_pkg;

  typedef enum logic [2:0] {
    IDLE,
    MOVING,
    OPENING,
    OPEN,
    CLOSING
  } state_t;

  typedef enum logic {
    UP   = 1'b0,
    DOWN = 1'b1
  } dir_t;

  localparam int LIFT_NUM_FLOORS    = 11;
  localparam int LIFT_TRAVEL_CYCLES = 8;
  localparam int LIFT_DOOR_CYCLES   = 4;

  // Width of a down-counter that has to hold the longer of the two phase lengths.
  function automatic int cnt_width(input int travel, input int door);
    int mx;
    mx = (travel > door) ? travel : door;
    return $clog2(mx + 1);
  endfunction

endpackage

// File: rtl/lift_call_scan.sv
// Call scanner: finds pending calls above/below/at the cabin and the SCAN direction.
// Latency: purely combinational.
// Backpressure: none.
module lift_call_scan
  import lift_pkg::*;
#(
  parameter int NUM_FLOORS = LIFT_NUM_FLOORS,
  localparam int FW = $clog2(NUM_FLOORS)
) (
  input  logic [NUM_FLOORS-1:0] pending,
  input  logic [FW-1:0]         cur_floor,
  input  logic                  dir,
  output logic                  any_above,
  output logic                  any_below,
  output logic                  here,
  output logic                  next_dir
);

  assign here = pending[cur_floor];

  // Split the call vector around the cabin and keep going the current way while it still has work.
  always_comb begin
    any_above = 1'b0;
    any_below = 1'b0;
    for (int i = 0; i < NUM_FLOORS; i++) begin
      if (FW'(i) > cur_floor) any_above = any_above | pending[i];
      if (FW'(i) < cur_floor) any_below = any_below | pending[i];
    end
    next_dir = dir;
    if (dir == UP) begin
      if (!any_above && any_below) next_dir = DOWN;
    end else begin
      if (!any_below && any_above) next_dir = UP;
    end
  end

endmodule

// File: rtl/lift_ctrl_scan.sv
// SCAN-ordered lift controller: call latching, travel timing and door sequencing.
// Latency: outputs registered, reflecting the state one cycle after the deciding edge.
// Backpressure: none; calls are latched and held until served.
module lift_ctrl_scan
  import lift_pkg::*;
#(
  parameter int NUM_FLOORS    = LIFT_NUM_FLOORS,
  parameter int TRAVEL_CYCLES = LIFT_TRAVEL_CYCLES,
  parameter int DOOR_CYCLES   = LIFT_DOOR_CYCLES,
  localparam int FW = $clog2(NUM_FLOORS)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NUM_FLOORS-1:0] req,
  input  logic                  door_obstacle,
  input  logic                  door_open_btn,
  input  logic                  door_close_btn,
  output logic                  up,
  output logic                  down,
  output logic                  door_opening,
  output logic                  door_closing,
  output logic                  ready,
  output logic [FW-1:0]         cur_floor,
  output logic [NUM_FLOORS-1:0] pending
);

  localparam int CW = cnt_width(TRAVEL_CYCLES, DOOR_CYCLES);
  localparam logic [CW-1:0] TRAVEL_LOAD = CW'(TRAVEL_CYCLES - 1);
  localparam logic [CW-1:0] DOOR_LOAD   = CW'(DOOR_CYCLES - 1);

  state_t                state, state_nxt;
  dir_t                  dir, dir_nxt;
  logic [FW-1:0]         floor_q, floor_nxt, step_floor;
  logic [NUM_FLOORS-1:0] pend_q, pend_nxt, pend_eff;
  logic [CW-1:0]         cnt, cnt_nxt;
  logic                  any_above, any_below, here, scan_dir;

  // New calls are visible to this cycle's decisions as well as being latched.
  assign pend_eff  = pend_q | req;
  assign cur_floor = floor_q;
  assign pending   = pend_q;

  lift_call_scan #(
    .NUM_FLOORS (NUM_FLOORS)
  ) u_scan (
    .pending   (pend_eff),
    .cur_floor (floor_q),
    .dir       (dir),
    .any_above (any_above),
    .any_below (any_below),
    .here      (here),
    .next_dir  (scan_dir)
  );

  // Next-state logic: idle dispatch, per-floor travel timing, door sequence and SCAN re-dispatch.
  always_comb begin
    state_nxt  = state;
    dir_nxt    = dir;
    floor_nxt  = floor_q;
    cnt_nxt    = cnt;
    step_floor = floor_q;
    pend_nxt   = pend_eff;
    case (state)
      IDLE: begin
        if (here) begin
          state_nxt = OPENING;
          cnt_nxt   = DOOR_LOAD;
        end else if (any_above || any_below) begin
          state_nxt = MOVING;
          dir_nxt   = dir_t'(scan_dir);
          cnt_nxt   = TRAVEL_LOAD;
        end
      end
      MOVING: begin
        if (cnt != '0) begin
          cnt_nxt = cnt - 1'b1;
        end else if ((dir == UP && !any_above) || (dir == DOWN && !any_below)) begin
          // Nothing lies ahead: refuse the step, which also keeps the cabin inside the shaft.
          state_nxt = IDLE;
          cnt_nxt   = '0;
        end else begin
          step_floor = (dir == UP) ? floor_q + FW'(1) : floor_q - FW'(1);
          floor_nxt  = step_floor;
          cnt_nxt    = TRAVEL_LOAD;
          if (pend_eff[step_floor]) begin
            state_nxt = OPENING;
            cnt_nxt   = DOOR_LOAD;
          end
        end
      end
      OPENING: begin
        if (cnt != '0) begin
          cnt_nxt = cnt - 1'b1;
        end else begin
          state_nxt = OPEN;
          cnt_nxt   = DOOR_LOAD;
        end
      end
      OPEN: begin
        if (door_open_btn) begin
          cnt_nxt = DOOR_LOAD;
        end else if ((door_close_btn && !door_obstacle) || cnt == '0) begin
          state_nxt = CLOSING;
          cnt_nxt   = DOOR_LOAD;
        end else begin
          cnt_nxt = cnt - 1'b1;
        end
      end
      CLOSING: begin
        if (door_obstacle || door_open_btn) begin
          state_nxt = OPENING;
          cnt_nxt   = DOOR_LOAD;
        end else if (cnt != '0) begin
          cnt_nxt = cnt - 1'b1;
        end else if (here) begin
          state_nxt = OPENING;
          cnt_nxt   = DOOR_LOAD;
        end else if (any_above || any_below) begin
          state_nxt = MOVING;
          dir_nxt   = dir_t'(scan_dir);
          cnt_nxt   = TRAVEL_LOAD;
        end else begin
          state_nxt = IDLE;
          cnt_nxt   = '0;
        end
      end
      default: begin
        state_nxt = IDLE;
        cnt_nxt   = '0;
      end
    endcase
    // Serving a floor clears its call even if the button is still pressed this cycle.
    if (state_nxt == OPENING && state != OPENING) pend_nxt[floor_nxt] = 1'b0;
  end

  // State register and output flops decoded from the state being entered.
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      dir          <= UP;
      floor_q      <= '0;
      pend_q       <= '0;
      cnt          <= '0;
      up           <= 1'b0;
      down         <= 1'b0;
      door_opening <= 1'b0;
      door_closing <= 1'b0;
      ready        <= 1'b1;
    end else begin
      state        <= state_nxt;
      dir          <= dir_nxt;
      floor_q      <= floor_nxt;
      pend_q       <= pend_nxt;
      cnt          <= cnt_nxt;
      up           <= (state_nxt == MOVING) && (dir_nxt == UP);
      down         <= (state_nxt == MOVING) && (dir_nxt == DOWN);
      door_opening <= (state_nxt == OPENING);
      door_closing <= (state_nxt == CLOSING);
      ready        <= (state_nxt == IDLE) && (pend_nxt == '0);
    end
  end

endmodule

// File: tb/tb_lift_ctrl_scan.sv
// Directed bench for the SCAN lift controller: default instance plus a 4-floor, 1-cycle-travel instance.
// Latency: checks sample on the falling edge, half a cycle after each decision edge.
// Backpressure: none.
module tb_lift_ctrl_scan;

  logic        clk;
  logic        rst, rst_b;
  logic [10:0] req;
  logic [3:0]  req_b;
  logic        door_obstacle, door_open_btn, door_close_btn;
  logic        up, down, door_opening, door_closing, ready;
  logic [3:0]  cur_floor;
  logic [10:0] pending;
  logic        up_b, down_b, door_opening_b, door_closing_b, ready_b;
  logic [1:0]  cur_floor_b;
  logic [3:0]  pending_b;
  logic        zero_b;

  int tests = 0;
  int fails = 0;
  int n;

  lift_ctrl_scan dut (
    .clk(clk), .rst(rst), .req(req),
    .door_obstacle(door_obstacle), .door_open_btn(door_open_btn), .door_close_btn(door_close_btn),
    .up(up), .down(down), .door_opening(door_opening), .door_closing(door_closing),
    .ready(ready), .cur_floor(cur_floor), .pending(pending)
  );

  lift_ctrl_scan #(.NUM_FLOORS(4), .TRAVEL_CYCLES(1), .DOOR_CYCLES(4)) dut_b (
    .clk(clk), .rst(rst_b), .req(req_b),
    .door_obstacle(zero_b), .door_open_btn(zero_b), .door_close_btn(zero_b),
    .up(up_b), .down(down_b), .door_opening(door_opening_b), .door_closing(door_closing_b),
    .ready(ready_b), .cur_floor(cur_floor_b), .pending(pending_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // 0 opening, 1 closing, 2 ready, 3 up, 4 down, 5 door held open, 6 any motor
  function automatic logic probe(input int which);
    case (which)
      0: return door_opening;
      1: return door_closing;
      2: return ready;
      3: return up;
      4: return down;
      5: return !up && !down && !door_opening && !door_closing && !ready;
      6: return up || down;
      default: return 1'b0;
    endcase
  endfunction

  task automatic wait_on(input string tag, input int which, input int lim);
    int k;
    k = 0;
    while (!probe(which) && k < lim) begin
      @(negedge clk);
      k++;
    end
    chk({tag, "_reached"}, 64'(k < lim), 64'd1);
  endtask

  task automatic run_len(input int which, output int len);
    len = 0;
    while (probe(which) && len < 200) begin
      @(negedge clk);
      len++;
    end
  endtask

  // Motor/door exclusivity on both instances every cycle.
  always @(negedge clk) begin
    if (!rst) begin
      tests++;
      assert (!(up && down) && !((up || down) && (door_opening || door_closing))) else begin
        fails++;
        $error("FAIL excl_a: up=%0b down=%0b opening=%0b closing=%0b required exclusive", up, down, door_opening, door_closing);
      end
    end
    if (!rst_b) begin
      tests++;
      assert (!(up_b && down_b) && !((up_b || down_b) && (door_opening_b || door_closing_b))) else begin
        fails++;
        $error("FAIL excl_b: up=%0b down=%0b opening=%0b closing=%0b required exclusive", up_b, down_b, door_opening_b, door_closing_b);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit expired");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; rst_b = 1'b1; zero_b = 1'b0;
    req = '1; req_b = '0;
    door_obstacle = 1'b0; door_open_btn = 1'b0; door_close_btn = 1'b0;
    repeat (3) @(negedge clk);

    // Reset values, with calls asserted and ignored
    chk("rst_ready", ready, 1);
    chk("rst_up", up, 0);
    chk("rst_down", down, 0);
    chk("rst_opening", door_opening, 0);
    chk("rst_floor", cur_floor, 0);
    chk("rst_pending", pending, 0);

    // Single call to floor 3: 24 cycles up, then 4/4/4 door phases
    rst = 1'b0; req = 11'h008;
    @(negedge clk); req = '0;
    chk("p3_pending", pending, 11'h008);
    run_len(3, n);
    chk("p3_up_cycles", n, 24);
    chk("p3_arrive_open", door_opening, 1);
    chk("p3_floor", cur_floor, 3);
    chk("p3_pending_clr", pending, 0);
    run_len(0, n);
    chk("p3_opening_len", n, 4);
    run_len(5, n);
    chk("p3_open_len", n, 4);
    run_len(1, n);
    chk("p3_closing_len", n, 4);
    chk("p3_ready", ready, 1);
    chk("p3_pending_end", pending, 0);

    // Call at the current floor 0: door opens on the next cycle, no motor
    rst = 1'b1; @(negedge clk); rst = 1'b0;
    req = 11'h001;
    @(negedge clk); req = '0;
    chk("f0_opening", door_opening, 1);
    chk("f0_no_motor", {up, down}, 2'b00);
    chk("f0_pending", pending, 0);
    run_len(0, n);
    // open and close pressed together: open wins and the door stays open
    door_open_btn = 1'b1; door_close_btn = 1'b1;
    @(negedge clk); door_open_btn = 1'b0;
    chk("f0_open_wins", {door_closing, door_opening}, 2'b00);
    @(negedge clk); door_close_btn = 1'b0;
    chk("f0_close_btn", door_closing, 1);
    wait_on("f0_idle", 2, 50);
    chk("f0_floor", cur_floor, 0);

    // Top floor: reach 10 and never step past it
    req = 11'h400;
    @(negedge clk); req = '0;
    wait_on("top_open", 0, 200);
    chk("top_floor", cur_floor, 10);
    wait_on("top_idle", 2, 50);
    repeat (5) @(negedge clk);
    chk("top_stay", {cur_floor, up}, {4'd10, 1'b0});

    // SCAN order: heading up past 5 with calls {2,7,9} -> 7, 9, then 2
    rst = 1'b1; @(negedge clk); rst = 1'b0;
    req = 11'h280;
    @(negedge clk); req = '0;
    n = 0;
    while (cur_floor != 4'd5 && n < 200) begin @(negedge clk); n++; end
    chk("scan_at5_up", up, 1);
    req = 11'h004;
    @(negedge clk); req = '0;
    wait_on("scan_open7", 0, 100);
    chk("scan_first", cur_floor, 7);
    chk("scan_pend7", pending, 11'h204);
    wait_on("scan_move7", 6, 100);
    chk("scan_dir_after7", {up, down}, 2'b10);
    wait_on("scan_open9", 0, 100);
    chk("scan_second", cur_floor, 9);
    chk("scan_pend9", pending, 11'h004);
    wait_on("scan_move9", 6, 100);
    chk("scan_dir_after9", {up, down}, 2'b01);
    wait_on("scan_open2", 0, 200);
    chk("scan_third", cur_floor, 2);
    chk("scan_pend2", pending, 0);

    // Obstacle on the 2nd closing cycle reopens fully, then a fresh open/close
    wait_on("obs_closing", 1, 50);
    @(negedge clk);
    door_obstacle = 1'b1;
    @(negedge clk); door_obstacle = 1'b0;
    chk("obs_reopen", door_opening, 1);
    run_len(0, n);
    chk("obs_reopen_len", n, 4);
    run_len(5, n);
    chk("obs_open_len", n, 4);
    run_len(1, n);
    chk("obs_close_len", n, 4);
    chk("obs_ready", ready, 1);

    // Reset between floors 4 and 5 drops position and the call to 8
    req = 11'h100;
    @(negedge clk); req = '0;
    n = 0;
    while (cur_floor != 4'd4 && n < 200) begin @(negedge clk); n++; end
    repeat (3) @(negedge clk);
    chk("rmid_moving", up, 1);
    rst = 1'b1;
    @(negedge clk);
    chk("rmid_floor", cur_floor, 0);
    chk("rmid_up", up, 0);
    chk("rmid_pending", pending, 0);
    rst = 1'b0;
    repeat (20) @(negedge clk);
    chk("rmid_lost", {cur_floor, up, ready}, {4'd0, 1'b0, 1'b1});

    // Small shaft, one cycle per floor: floor 0 to 3 in 3 cycles
    rst_b = 1'b0; req_b = 4'b1000;
    @(negedge clk); req_b = '0;
    n = 0;
    while (up_b && n < 50) begin @(negedge clk); n++; end
    chk("b_up_cycles", n, 3);
    chk("b_opening", door_opening_b, 1);
    chk("b_floor", cur_floor_b, 3);
    n = 0;
    while (!ready_b && n < 50) begin @(negedge clk); n++; end
    chk("b_ready", {ready_b, cur_floor_b, pending_b}, {1'b1, 2'd3, 4'd0});

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
